ysyx_icache: RTL



---
 rtl/ysyx_icache_pkg.sv | 21 ++
 rtl/ysyx_icache_if.sv | 25 ++
 rtl/ysyx_icache_array.sv | 45 ++++
 rtl/ysyx_icache.sv | 113 +++++++++++
 4 files changed

// File: rtl/ysyx_icache_pkg.sv
// ysyx_icache_pkg: shared state encoding and geometry helpers for the instruction cache.
package ysyx_icache_pkg;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_SET_BITS = 4;
    localparam int DEF_OFF_BITS = 4;
    localparam int TAG_W        = DEF_ADDR_W - DEF_SET_BITS - DEF_OFF_BITS;
    localparam int WORDS        = 2 ** (DEF_OFF_BITS - 2);

    typedef enum logic [1:0] {IDLE, REFILL, RESP} icache_state_t;

    function automatic int tag_bits(input int addr_w, input int set_bits, input int off_bits);
        return addr_w - set_bits - off_bits;
    endfunction

    function automatic int line_words(input int off_bits);
        return 2 ** (off_bits - 2);
    endfunction

endpackage

// File: rtl/ysyx_icache_if.sv
// ysyx_icache_if: IFU fetch port plus refill bus port; slave is the cache side.
interface ysyx_icache_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] ifu_araddr;
    logic              ifu_arvalid;
    logic [DATA_W-1:0] ifu_rdata_o;
    logic              ifu_rvalid_o;
    logic              flush;
    logic [ADDR_W-1:0] bus_araddr_o;
    logic              bus_arvalid_o;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_rvalid;

    modport slave (
        input  ifu_araddr, ifu_arvalid, flush, bus_rdata, bus_rvalid,
        output ifu_rdata_o, ifu_rvalid_o, bus_araddr_o, bus_arvalid_o
    );

    modport master (
        output ifu_araddr, ifu_arvalid, flush, bus_rdata, bus_rvalid,
        input  ifu_rdata_o, ifu_rvalid_o, bus_araddr_o, bus_arvalid_o
    );
endinterface

// File: rtl/ysyx_icache_array.sv
// ysyx_icache_array: tag/valid/data storage, asynchronous read, synchronous writes.
module ysyx_icache_array import ysyx_icache_pkg::*; #(
    parameter int SET_BITS = DEF_SET_BITS,
    parameter int OFF_BITS = DEF_OFF_BITS,
    parameter int TW       = TAG_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [SET_BITS-1:0]   rd_idx,
    input  logic [OFF_BITS-3:0]   rd_sel,
    output logic                  rd_valid,
    output logic [TW-1:0]         rd_tag,
    output logic [DATA_W-1:0]     rd_word,
    input  logic                  we,
    input  logic [SET_BITS-1:0]   w_idx,
    input  logic [OFF_BITS-3:0]   w_sel,
    input  logic [DATA_W-1:0]     w_data,
    input  logic                  tag_we,
    input  logic [TW-1:0]         w_tag,
    input  logic                  w_valid
);
    localparam int SETS = 2 ** SET_BITS;
    localparam int NW   = line_words(OFF_BITS);

    logic [SETS-1:0]   valid;
    logic [TW-1:0]     tags [SETS];
    logic [DATA_W-1:0] data [SETS][NW];

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_word  = data[rd_idx][rd_sel];

    // Flush wins over a same-cycle tag write so a coincident fence.i never leaves a line valid.
    always_ff @(posedge clk) begin
        if (rst || flush) valid <= '0;
        else if (tag_we) valid[w_idx] <= w_valid;
    end

    always_ff @(posedge clk) begin
        if (tag_we) tags[w_idx] <= w_tag;
        if (we) data[w_idx][w_sel] <= w_data;
    end
endmodule

// File: rtl/ysyx_icache.sv
// ysyx_icache: direct-mapped I-cache with 4-word line refill and fence.i flush.
// Optional perf counters hit_cnt_o/miss_cnt_o are built when YSYX_ICACHE_PERF_EN is defined.
module ysyx_icache import ysyx_icache_pkg::*; #(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SET_BITS = DEF_SET_BITS,
    parameter int OFF_BITS = DEF_OFF_BITS
) (
    input  logic        clk,
    input  logic        rst,
`ifdef YSYX_ICACHE_PERF_EN
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o,
`endif
    ysyx_icache_if.slave io
);
    localparam int TW = tag_bits(ADDR_W, SET_BITS, OFF_BITS);
    localparam int WB = OFF_BITS - 2;
    localparam int LW = ADDR_W - OFF_BITS;

    icache_state_t     state, state_nx;
    logic [WB-1:0]     cnt, req_word;
    logic [LW-1:0]     base;
    logic              drop;
    logic [DATA_W-1:0] rdata_q;
    logic              rd_valid;
    logic [TW-1:0]     rd_tag;
    logic [DATA_W-1:0] rd_word;
    logic              lookup, hit, beat, last_beat, unused_ok;

    assign lookup    = state == IDLE && io.ifu_arvalid;
    assign hit       = rd_valid && rd_tag == io.ifu_araddr[ADDR_W-1 -: TW] && !io.flush;
    assign beat      = state == REFILL && io.bus_rvalid;
    assign last_beat = beat && &cnt;
    assign unused_ok = ^io.ifu_araddr[1:0];

    ysyx_icache_array #(
        .SET_BITS(SET_BITS),
        .OFF_BITS(OFF_BITS),
        .TW      (TW),
        .DATA_W  (DATA_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .flush   (io.flush),
        .rd_idx  (io.ifu_araddr[OFF_BITS +: SET_BITS]),
        .rd_sel  (io.ifu_araddr[2 +: WB]),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_word (rd_word),
        .we      (beat),
        .w_idx   (base[SET_BITS-1:0]),
        .w_sel   (cnt),
        .w_data  (io.bus_rdata),
        .tag_we  (last_beat),
        .w_tag   (base[LW-1 -: TW]),
        .w_valid (!(drop || io.flush))
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE   ? (io.ifu_arvalid ? (hit ? RESP : REFILL) : IDLE) :
                   state == REFILL ? (last_beat ? RESP : REFILL) : IDLE;
    end

    always_comb begin
        io.bus_arvalid_o = state == REFILL;
        io.bus_araddr_o  = {base, cnt, 2'b00};
        io.ifu_rvalid_o  = state == RESP;
        io.ifu_rdata_o   = rdata_q;
    end

    // The requested word is taken straight off the bus so the response never re-reads the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            req_word <= '0;
            base     <= '0;
            drop     <= 1'b0;
            rdata_q  <= '0;
        end else if (lookup) begin
            if (hit) rdata_q <= rd_word;
            else begin
                base     <= io.ifu_araddr[ADDR_W-1:OFF_BITS];
                cnt      <= '0;
                req_word <= io.ifu_araddr[2 +: WB];
                drop     <= 1'b0;
            end
        end else if (state == REFILL) begin
            if (io.flush) drop <= 1'b1;
            if (io.bus_rvalid) begin
                cnt <= cnt + 1'b1;
                if (cnt == req_word) rdata_q <= io.bus_rdata;
            end
        end
    end

`ifdef YSYX_ICACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (lookup) begin
            if (hit) hit_cnt_o <= hit_cnt_o + 32'd1;
            else miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif
endmodule
